// File: rtl/csc_rgb2ycbcr_param_if.sv
// Video bus for the RGB-to-YCbCr converter: input sync/pixels, mode request,
// delayed output sync, YCbCr pixels and the currently applied matrix.
interface csc_rgb2ycbcr_param_if #(
    parameter int R_W = 5,
    parameter int G_W = 6,
    parameter int B_W = 5
);
    logic           mode_sel;
    logic           pre_frame_vsync;
    logic           pre_frame_hsync;
    logic           pre_frame_de;
    logic [R_W-1:0] img_red;
    logic [G_W-1:0] img_green;
    logic [B_W-1:0] img_blue;
    logic           post_frame_vsync;
    logic           post_frame_hsync;
    logic           post_frame_de;
    logic [7:0]     img_y;
    logic [7:0]     img_cb;
    logic [7:0]     img_cr;
    logic           active_mode;

    modport master (
        output mode_sel, pre_frame_vsync, pre_frame_hsync, pre_frame_de,
               img_red, img_green, img_blue,
        input  post_frame_vsync, post_frame_hsync, post_frame_de,
               img_y, img_cb, img_cr, active_mode
    );

    modport slave (
        input  mode_sel, pre_frame_vsync, pre_frame_hsync, pre_frame_de,
               img_red, img_green, img_blue,
        output post_frame_vsync, post_frame_hsync, post_frame_de,
               img_y, img_cb, img_cr, active_mode
    );
endinterface

// File: rtl/csc_rgb2ycbcr_param.sv
// RGB to YCbCr (BT.601 / BT.709 full range), 4-stage pipeline, matrix latched at vsync rise.
// Define CSC_ROUND_EN for round-to-nearest with saturation; default is truncation.
module csc_rgb2ycbcr_param #(
    parameter int R_W = 5,
    parameter int G_W = 6,
    parameter int B_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    csc_rgb2ycbcr_param_if.slave  vif
);
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int STAGES = 4;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + 1;

    // Coefficient magnitudes; signs are fixed by the sum structure in stage 3.
    typedef struct packed {
        logic [COEF_W-1:0] y_r, y_g, y_b, cb_r, cb_g, cr_g, cr_b;
    } coef_t;

    function automatic coef_t coef_sel(input logic bt709);
        coef_t c;
        if (bt709) begin
            c.y_r = 8'd54;  c.y_g = 8'd183; c.y_b = 8'd18;
            c.cb_r = 8'd29; c.cb_g = 8'd99;
            c.cr_g = 8'd116; c.cr_b = 8'd12;
        end else begin
            c.y_r = 8'd77;  c.y_g = 8'd150; c.y_b = 8'd29;
            c.cb_r = 8'd43; c.cb_g = 8'd85;
            c.cr_g = 8'd107; c.cr_b = 8'd21;
        end
        return c;
    endfunction

    function automatic logic [PROD_W-1:0] mul(input logic [DATA_W-1:0] a,
                                               input logic [COEF_W-1:0] c);
        return {{COEF_W{1'b0}}, a} * {{DATA_W{1'b0}}, c};
    endfunction

    // The +32768 offset lands the final value in 0..65408, so any wrap of
    // intermediate terms in 17 bits cancels out.
    function automatic logic [SUM_W-1:0] chroma_sum(input logic [PROD_W-1:0] pos,
                                                     input logic [PROD_W-1:0] neg_a,
                                                     input logic [PROD_W-1:0] neg_b);
        logic signed [SUM_W-1:0] acc;
        acc = $signed({1'b0, pos}) - $signed({1'b0, neg_a})
            - $signed({1'b0, neg_b}) + 17'sd32768;
        return $unsigned(acc);
    endfunction

    function automatic logic [DATA_W-1:0] round_sat(input logic [SUM_W-1:0] s);
`ifdef CSC_ROUND_EN
        logic [SUM_W-1:0] t;
        t = s + 17'd128;
        return t[16] ? 8'hFF : t[15:8];
`else
        logic unused_bits;
        unused_bits = ^{s[16], s[7:0]};
        return s[15:8];
`endif
    endfunction

    logic [DATA_W-1:0] r_exp, g_exp, b_exp;

    generate
        if (R_W == DATA_W) begin : g_r_pass
            assign r_exp = vif.img_red;
        end else begin : g_r_rep
            assign r_exp = {vif.img_red, vif.img_red[R_W-1 -: DATA_W-R_W]};
        end
        if (G_W == DATA_W) begin : g_g_pass
            assign g_exp = vif.img_green;
        end else begin : g_g_rep
            assign g_exp = {vif.img_green, vif.img_green[G_W-1 -: DATA_W-G_W]};
        end
        if (B_W == DATA_W) begin : g_b_pass
            assign b_exp = vif.img_blue;
        end else begin : g_b_rep
            assign b_exp = {vif.img_blue, vif.img_blue[B_W-1 -: DATA_W-B_W]};
        end
    endgenerate

    logic vs_d, mode_q, vs_rise, mode_eff;

    // The capturing cycle itself already uses the newly requested matrix.
    assign vs_rise  = vif.pre_frame_vsync & ~vs_d;
    assign mode_eff = vs_rise ? vif.mode_sel : mode_q;

    logic [DATA_W-1:0] r_p1, g_p1, b_p1;
    coef_t             coef_p1;
    logic [PROD_W-1:0] yr_p2, yg_p2, yb_p2, cbr_p2, cbg_p2, cbb_p2, crr_p2, crg_p2, crb_p2;
    logic [SUM_W-1:0]  y_p3, cb_p3, cr_p3;
    logic [DATA_W-1:0] y_p4, cb_p4, cr_p4;
    logic [STAGES-1:0] vs_p, hs_p, vld_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d    <= 1'b0;
            mode_q  <= 1'b0;
            r_p1    <= '0;
            g_p1    <= '0;
            b_p1    <= '0;
            coef_p1 <= '0;
            yr_p2   <= '0;
            yg_p2   <= '0;
            yb_p2   <= '0;
            cbr_p2  <= '0;
            cbg_p2  <= '0;
            cbb_p2  <= '0;
            crr_p2  <= '0;
            crg_p2  <= '0;
            crb_p2  <= '0;
            y_p3    <= '0;
            cb_p3   <= '0;
            cr_p3   <= '0;
            y_p4    <= '0;
            cb_p4   <= '0;
            cr_p4   <= '0;
            vs_p    <= '0;
            hs_p    <= '0;
            vld_p   <= '0;
        end else begin
            vs_d <= vif.pre_frame_vsync;
            if (vs_rise) begin
                mode_q <= vif.mode_sel;
            end
            // Stage 1: expanded components and selected coefficient set
            r_p1    <= r_exp;
            g_p1    <= g_exp;
            b_p1    <= b_exp;
            coef_p1 <= coef_sel(mode_eff);
            // Stage 2: nine unsigned products
            yr_p2  <= mul(r_p1, coef_p1.y_r);
            yg_p2  <= mul(g_p1, coef_p1.y_g);
            yb_p2  <= mul(b_p1, coef_p1.y_b);
            cbr_p2 <= mul(r_p1, coef_p1.cb_r);
            cbg_p2 <= mul(g_p1, coef_p1.cb_g);
            cbb_p2 <= mul(b_p1, 8'd128);
            crr_p2 <= mul(r_p1, 8'd128);
            crg_p2 <= mul(g_p1, coef_p1.cr_g);
            crb_p2 <= mul(b_p1, coef_p1.cr_b);
            // Stage 3: 17-bit sums
            y_p3  <= {1'b0, yr_p2} + {1'b0, yg_p2} + {1'b0, yb_p2};
            cb_p3 <= chroma_sum(cbb_p2, cbr_p2, cbg_p2);
            cr_p3 <= chroma_sum(crr_p2, crg_p2, crb_p2);
            // Stage 4: 8-bit outputs
            y_p4  <= round_sat(y_p3);
            cb_p4 <= round_sat(cb_p3);
            cr_p4 <= round_sat(cr_p3);
            vs_p  <= {vs_p[STAGES-2:0], vif.pre_frame_vsync};
            hs_p  <= {hs_p[STAGES-2:0], vif.pre_frame_hsync};
            vld_p <= {vld_p[STAGES-2:0], vif.pre_frame_de};
        end
    end

    assign vif.post_frame_vsync = vs_p[STAGES-1];
    assign vif.post_frame_hsync = hs_p[STAGES-1];
    assign vif.post_frame_de    = vld_p[STAGES-1];
    assign vif.img_y            = vld_p[STAGES-1] ? y_p4  : 8'd0;
    assign vif.img_cb           = vld_p[STAGES-1] ? cb_p4 : 8'd0;
    assign vif.img_cr           = vld_p[STAGES-1] ? cr_p4 : 8'd0;
    assign vif.active_mode      = mode_q;

endmodule

// File: tb/tb_csc_rgb2ycbcr_param.sv
// Scoreboard bench for csc_rgb2ycbcr_param: three width configurations (5/6/5, 8/8/8, 4/4/4)
// share one stimulus stream; expectations come from an arithmetic model of the converter.
module tb_csc_rgb2ycbcr_param;
    localparam int NDUT = 3;

`ifdef CSC_ROUND_EN
    localparam int RED601_Y  = 77;
    localparam int BLUE709_Y = 18;
`else
    localparam int RED601_Y  = 76;
    localparam int BLUE709_Y = 17;
`endif

    typedef struct {
        logic       vs, hs, de;
        logic [7:0] y, cb, cr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csc_rgb2ycbcr_param_if #(.R_W(5), .G_W(6), .B_W(5)) if_a ();
    csc_rgb2ycbcr_param_if #(.R_W(8), .G_W(8), .B_W(8)) if_b ();
    csc_rgb2ycbcr_param_if #(.R_W(4), .G_W(4), .B_W(4)) if_c ();

    csc_rgb2ycbcr_param #(.R_W(5), .G_W(6), .B_W(5)) u_dut_a (.clk(clk), .rst_n(rst_n), .vif(if_a));
    csc_rgb2ycbcr_param #(.R_W(8), .G_W(8), .B_W(8)) u_dut_b (.clk(clk), .rst_n(rst_n), .vif(if_b));
    csc_rgb2ycbcr_param #(.R_W(4), .G_W(4), .B_W(4)) u_dut_c (.clk(clk), .rst_n(rst_n), .vif(if_c));

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[NDUT][$];
    bit   m_vs_prev, m_mode;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int width(input int d, input int c);
        if (d == 1) return 8;
        if (d == 2) return 4;
        return (c == 1) ? 6 : 5;
    endfunction

    function automatic int expand(input int c, input int w);
        if (w == 8) return c;
        return (c << (8 - w)) | (c >> (2 * w - 8));
    endfunction

    function automatic int out8(input int s);
        int t;
        t = s;
`ifdef CSC_ROUND_EN
        t = t + 128;
        if (t > 65535) return 255;
`endif
        return (t >> 8) & 255;
    endfunction

    function automatic exp_t model(input bit vs, hs, de, mode, input int r, g, b);
        exp_t e;
        int yr, yg, yb, cbr, cbg, crg, crb, sy, scb, scr;
        if (mode) begin
            yr = 54; yg = 183; yb = 18; cbr = 29; cbg = 99; crg = 116; crb = 12;
        end else begin
            yr = 77; yg = 150; yb = 29; cbr = 43; cbg = 85; crg = 107; crb = 21;
        end
        sy  = r * yr + g * yg + b * yb;
        scb = b * 128 - r * cbr - g * cbg + 32768;
        scr = r * 128 - g * crg - b * crb + 32768;
        e.vs = vs; e.hs = hs; e.de = de;
        e.y  = de ? 8'(out8(sy))  : 8'd0;
        e.cb = de ? 8'(out8(scb)) : 8'd0;
        e.cr = de ? 8'(out8(scr)) : 8'd0;
        return e;
    endfunction

    task automatic set_in(input int d, input bit vs, hs, de, ms, input int r, g, b);
        case (d)
            0: begin
                if_a.pre_frame_vsync = vs; if_a.pre_frame_hsync = hs; if_a.pre_frame_de = de;
                if_a.mode_sel = ms; if_a.img_red = 5'(r); if_a.img_green = 6'(g); if_a.img_blue = 5'(b);
            end
            1: begin
                if_b.pre_frame_vsync = vs; if_b.pre_frame_hsync = hs; if_b.pre_frame_de = de;
                if_b.mode_sel = ms; if_b.img_red = 8'(r); if_b.img_green = 8'(g); if_b.img_blue = 8'(b);
            end
            default: begin
                if_c.pre_frame_vsync = vs; if_c.pre_frame_hsync = hs; if_c.pre_frame_de = de;
                if_c.mode_sel = ms; if_c.img_red = 4'(r); if_c.img_green = 4'(g); if_c.img_blue = 4'(b);
            end
        endcase
    endtask

    task automatic get_out(input int d, output exp_t o, output logic am);
        case (d)
            0: begin
                o.vs = if_a.post_frame_vsync; o.hs = if_a.post_frame_hsync; o.de = if_a.post_frame_de;
                o.y = if_a.img_y; o.cb = if_a.img_cb; o.cr = if_a.img_cr; am = if_a.active_mode;
            end
            1: begin
                o.vs = if_b.post_frame_vsync; o.hs = if_b.post_frame_hsync; o.de = if_b.post_frame_de;
                o.y = if_b.img_y; o.cb = if_b.img_cb; o.cr = if_b.img_cr; am = if_b.active_mode;
            end
            default: begin
                o.vs = if_c.post_frame_vsync; o.hs = if_c.post_frame_hsync; o.de = if_c.post_frame_de;
                o.y = if_c.img_y; o.cb = if_c.img_cb; o.cr = if_c.img_cr; am = if_c.active_mode;
            end
        endcase
    endtask

    task automatic compare_out(input int d, input string pfx, input exp_t o, input exp_t e);
        check($sformatf("%s_d%0d_vsync", pfx, d), 16'(o.vs), 16'(e.vs));
        check($sformatf("%s_d%0d_hsync", pfx, d), 16'(o.hs), 16'(e.hs));
        check($sformatf("%s_d%0d_de", pfx, d), 16'(o.de), 16'(e.de));
        check($sformatf("%s_d%0d_y", pfx, d), 16'(o.y), 16'(e.y));
        check($sformatf("%s_d%0d_cb", pfx, d), 16'(o.cb), 16'(e.cb));
        check($sformatf("%s_d%0d_cr", pfx, d), 16'(o.cr), 16'(e.cr));
    endtask

    task automatic check_zero_all(input string pfx);
        exp_t o, z;
        logic am;
        z = '{vs: 1'b0, hs: 1'b0, de: 1'b0, y: 8'd0, cb: 8'd0, cr: 8'd0};
        for (int d = 0; d < NDUT; d++) begin
            get_out(d, o, am);
            compare_out(d, pfx, o, z);
            check($sformatf("%s_d%0d_mode", pfx, d), 16'(am), 16'd0);
        end
    endtask

    task automatic compare_all();
        exp_t o, e;
        logic am;
        for (int d = 0; d < NDUT; d++) begin
            get_out(d, o, am);
            check($sformatf("d%0d_active_mode", d), 16'(am), 16'(m_mode));
            check($sformatf("d%0d_sb_depth", d), 16'(sb[d].size()), 16'd4);
            if (sb[d].size() > 0) begin
                e = sb[d].pop_front();
                compare_out(d, "pix", o, e);
            end
        end
    endtask

    // One pixel clock: check what leaves the pipeline, then drive and predict the next input.
    task automatic step(input bit vs, hs, de, ms, input int r, g, b,
                        input int ly = -1, input int lcb = -1, input int lcr = -1);
        bit   eff;
        int   rr, gg, bb;
        exp_t e;
        @(negedge clk);
        compare_all();
        eff = (vs && !m_vs_prev) ? ms : m_mode;
        if (vs && !m_vs_prev) m_mode = ms;
        m_vs_prev = vs;
        for (int d = 0; d < NDUT; d++) begin
            rr = r >> (8 - width(d, 0));
            gg = g >> (8 - width(d, 1));
            bb = b >> (8 - width(d, 2));
            set_in(d, vs, hs, de, ms, rr, gg, bb);
            e = model(vs, hs, de, eff, expand(rr, width(d, 0)), expand(gg, width(d, 1)),
                      expand(bb, width(d, 2)));
            if (ly >= 0 && de) begin
                e.y = 8'(ly); e.cb = 8'(lcb); e.cr = 8'(lcr);
            end
            sb[d].push_back(e);
        end
    endtask

    task automatic do_reset(input bit mid);
        exp_t z;
        z = '{vs: 1'b0, hs: 1'b0, de: 1'b0, y: 8'd0, cb: 8'd0, cr: 8'd0};
        if (mid) begin
            #2 rst_n = 1'b0;
            #1 check_zero_all("rst_async");
        end
        for (int d = 0; d < NDUT; d++) set_in(d, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        repeat (2) begin
            @(negedge clk);
            check_zero_all("rst_hold");
        end
        rst_n = 1'b1;
        m_vs_prev = 1'b0;
        m_mode = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            sb[d].delete();
            repeat (4) sb[d].push_back(z);
        end
    endtask

    task automatic random_pixels(input int n, input bit toggle_mode);
        int r, g, b;
        bit ms;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 255);
            g = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            ms = toggle_mode ? bit'(i % 2) : 1'b0;
            step(1'b0, 1'b0, 1'b1, ms, r, g, b);
        end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) set_in(d, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        do_reset(1'b0);

        // Frame 1, BT.601; mode_sel pulses while vsync is already high are ignored
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 255, 255, 255, 255, 128, 128);
        step(0, 0, 1, 0, 255, 0, 0, RED601_Y, 85, 255);
        step(0, 0, 1, 1, 0, 0, 0, 0, 128, 128);
        random_pixels(10, 1'b1);
        step(0, 0, 0, 1, 200, 100, 50);
        step(0, 1, 0, 0, 255, 255, 255);
        step(0, 0, 1, 0, 255, 255, 255, 255, 128, 128);
        step(0, 0, 1, 0, 80, 160, 240);

        // Reset mid-frame with pixels in flight
        do_reset(1'b1);
        step(0, 0, 1, 0, 255, 255, 255, 255, 128, 128);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Frame 2, BT.709; mode_sel toggles mid-frame must not change the matrix
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 255, 255, 255, 254, 128, 128);
        step(0, 0, 1, 1, 0, 0, 255, BLUE709_Y, 255, 116);
        step(0, 0, 1, 0, 0, 0, 0, 0, 128, 128);
        random_pixels(10, 1'b1);
        step(0, 0, 1, 0, 255, 255, 255, 254, 128, 128);

        // Frame 3 back to BT.601, switched exactly on the vsync rising edge
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 255, 0, 0, RED601_Y, 85, 255);
        random_pixels(8, 1'b0);
        step(0, 0, 0, 0, 255, 255, 255);

        repeat (4) step(0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/csc_rgb2ycbcr_param.md
Name: csc_rgb2ycbcr_param

Overview:
Parametrised RGB-to-YCbCr colour-space converter for the camera/plate-recognition video path, sitting between the pixel source and the threshold/binarisation stages. Accepts RGB of configurable component widths and selects BT.601 or BT.709 full-range coefficients per frame. The mode is latched only at frame start, so frames never tear. Uses a 4-stage pipeline with matched sync delay; output components are 8 bits.

Parameters:
R_W, 5, red input width; legal range 4..8
G_W, 6, green input width; legal range 4..8
B_W, 5, blue input width; legal range 4..8

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset; one clock, all flops reset asynchronously
mode_sel  in  1  requested matrix: 0 = BT.601, 1 = BT.709
pre_frame_vsync  in  1  input vsync, active high
pre_frame_hsync  in  1  input hsync
pre_frame_de  in  1  input data enable
img_red  in  R_W  red component
img_green  in  G_W  green component
img_blue  in  B_W  blue component
post_frame_vsync  out  1  vsync delayed 4 cycles
post_frame_hsync  out  1  hsync delayed 4 cycles
post_frame_de  out  1  de delayed 4 cycles
img_y  out  8  luma
img_cb  out  8  blue chroma
img_cr  out  8  red chroma
active_mode  out  1  matrix currently applied at the stage-1 input

Behaviour:
- Expansion to 8 bits uses MSB replication: comp8 = {c, c[W-1 -: 8-W]}. If W = 8, pass through unchanged.
- Coefficients (signed, /256):
  - BT.601: Y 77,150,29; Cb -43,-85,128; Cr 128,-107,-21.
  - BT.709: Y 54,183,18; Cb -29,-99,128; Cr 128,-116,-12.
- Mode latch:
  - A registered copy of pre_frame_vsync detects its rising edge.
  - On that cycle, mode_sel is captured into active_mode.
  - The capturing pixel cycle and all later pixels use the new value.
  - mode_sel changes at any other time have no effect.
  - active_mode resets to 0.
- Pipeline, latency exactly 4 cycles from input to output:
  - S1: register expanded R, G, B and the coefficient set.
  - S2: nine products, each 16-bit unsigned magnitude.
  - S3: sums in 17-bit width. Y = sum of products. Cb = B*128 - R*cr - G*cg + 32768. Cr = R*128 - G*cg - B*cb + 32768. Offset guarantees the results are non-negative (range 0..65408).
  - S4: output = sum[15:8], subject to the optional rounding feature.
- vsync, hsync and de each pass through a 4-deep shift register. Outputs are post_*[3].
- img_y/cb/cr equal the S4 register when post_frame_de = 1, else 8'd0.
- Pipeline stalls: none. Data is computed every cycle regardless of de.
- Reset (any time, including mid-frame):
  - All pipeline registers, sync delays and outputs go to 0; outputs read 0 immediately.
  - The first valid output appears 4 cycles after the first de following reset release.

Optional Feature:
CSC_ROUND_EN
- Defined: S4 adds 128 before taking [15:8] and saturates at 255 if bit 16 is set. This gives round-to-nearest.
- Undefined: plain truncation of sum[15:8] with no adder. Bit 16 is never set.

Test Plan:
1. Reset/latency: reset mid-frame, release, drive de=1 with R=31, G=63, B=31, mode 0 → all outputs 0 during reset; img_y=255, cb=128, cr=128 exactly 4 cycles after de; post_frame_de aligned.
2. BT.601 pure red (R=31, G=0, B=0): truncate → Y=76, Cb=85, Cr=255. CSC_ROUND_EN → Y=77, Cb=85, Cr=255 (saturated, no wrap to 0).
3. BT.709 white (mode_sel=1 latched at vsync, R=31, G=63, B=31) → Y=254, Cb=128, Cr=128. BT.709 pure blue → truncate Y=17, Cb=255, Cr=116; round Y=18, Cb=255, Cr=116.
4. Mode latch: toggle mode_sel mid-frame → active_mode unchanged and output values unchanged until the next vsync rising edge; active_mode flips on that edge cycle.
5. Blanking: de=0 with nonzero RGB → img_y/cb/cr = 0. Black pixel (0,0,0) with de=1 → Y=0, Cb=128, Cr=128.
6. Width parameters: R_W=G_W=B_W=8, inputs 255/0/0, mode 0 → same results as scenario 2. R_W=4, R=15 → expands to 255.
